// File: rtl/pc_ctrl_pkg.sv
// Shared types for the Gumnut instruction sequencer: PC operation codes,
// decoded instruction classes and sequencer states.
package pc_ctrl_pkg;

  typedef enum logic [3:0] {
    PC_INC  = 4'h0,
    PC_JMP  = 4'h1,
    PC_BZ   = 4'h2,
    PC_BNZ  = 4'h3,
    PC_BC   = 4'h4,
    PC_BNC  = 4'h5,
    PC_RET  = 4'h6,
    PC_RETI = 4'h7,
    PC_INT  = 4'h8
  } pc_oper_t;

  // Eighteen classes with distinct sequencing behaviour; five bits hold them all.
  typedef enum logic [4:0] {
    CLS_ALU   = 5'd0,
    CLS_SHIFT = 5'd1,
    CLS_BZ    = 5'd2,
    CLS_BNZ   = 5'd3,
    CLS_BC    = 5'd4,
    CLS_BNC   = 5'd5,
    CLS_JMP   = 5'd6,
    CLS_JSB   = 5'd7,
    CLS_RET   = 5'd8,
    CLS_RETI  = 5'd9,
    CLS_ENAI  = 5'd10,
    CLS_DISI  = 5'd11,
    CLS_LDM   = 5'd12,
    CLS_STM   = 5'd13,
    CLS_INP   = 5'd14,
    CLS_OUT   = 5'd15,
    CLS_WAIT  = 5'd16,
    CLS_STBY  = 5'd17
  } instr_class_t;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WBACK   = 3'd5,
    ST_INTR    = 3'd6,
    ST_SLEEP   = 3'd7
  } seq_state_t;

  localparam logic [11:0] ISR_VEC = 12'h001;

endpackage

// File: rtl/pc_sequencer.sv
// Multi-cycle sequencer: fetch/decode/execute/memory/writeback control for pc_unit,
// bus handshakes and interrupt entry at instruction boundaries.
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter bit INT_EN_RST = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst,
  input  logic         clkEn_i,
  input  instr_class_t class_i,
  input  logic         inst_ack_i,
  input  logic         data_ack_i,
  input  logic         int_req_i,
  output logic         inst_stb_o,
  output logic         irEn_o,
  output logic         data_stb_o,
  output logic         data_we_o,
  output logic         port_sel_o,
  output logic         regWe_o,
  output logic         flagWe_o,
  output logic         flagRestore_o,
  output logic [3:0]   PCoper_o,
  output logic         PCEn_o,
  output logic         int_o,
  output logic         push_o,
  output logic         pop_o,
  output logic         int_ack_o,
  output logic         ie_o,
  output logic         stby_o,
  output seq_state_t   state_o
);

  // Handshakes: a strobe (inst_stb_o / data_stb_o) stays high until the matching
  // ack is sampled on an enabled edge; the cycle the ack is seen is the transfer
  // cycle. Acks seen while no strobe is high have no effect.

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic       r_ie;
  logic       w_ie_nxt;
  logic       w_complete;
  logic       w_load;
  logic       w_store;
  logic       w_port;
  pc_oper_t   w_oper;

  assign w_load  = (class_i == CLS_LDM) || (class_i == CLS_INP);
  assign w_store = (class_i == CLS_STM) || (class_i == CLS_OUT);
  assign w_port  = (class_i == CLS_INP) || (class_i == CLS_OUT);

  always_comb begin
    w_state_nxt = r_state;
    w_ie_nxt    = r_ie;
    w_complete  = 1'b0;
    case (r_state)
      ST_RESET:  w_state_nxt = ST_FETCH;
      ST_FETCH:  if (inst_ack_i) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_EXECUTE;
      ST_EXECUTE: begin
        case (class_i)
          CLS_ENAI, CLS_RETI: w_ie_nxt = 1'b1;
          CLS_DISI:           w_ie_nxt = 1'b0;
          default:            ;
        endcase
        if (w_load || w_store)
          w_state_nxt = ST_MEM;
        else if ((class_i == CLS_WAIT) || (class_i == CLS_STBY))
          w_state_nxt = ST_SLEEP;
        else
          w_complete = 1'b1;
      end
      ST_MEM: begin
        if (data_ack_i) begin
          if (w_store) w_complete  = 1'b1;
          else         w_state_nxt = ST_WBACK;
        end
      end
      ST_WBACK: w_complete = 1'b1;
      ST_INTR: begin
        w_ie_nxt    = 1'b0;
        w_state_nxt = ST_FETCH;
      end
      ST_SLEEP: if (int_req_i && r_ie) w_state_nxt = ST_INTR;
      default:  w_state_nxt = ST_RESET;
    endcase
    // Boundary check sees the enable as the finishing instruction leaves it.
    if (w_complete)
      w_state_nxt = (int_req_i && w_ie_nxt) ? ST_INTR : ST_FETCH;
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RESET;
      r_ie    <= INT_EN_RST;
    end else if (clkEn_i) begin
      r_state <= w_state_nxt;
      r_ie    <= w_ie_nxt;
    end
  end

  always_comb begin
    inst_stb_o    = 1'b0;
    irEn_o        = 1'b0;
    data_stb_o    = 1'b0;
    data_we_o     = 1'b0;
    port_sel_o    = 1'b0;
    regWe_o       = 1'b0;
    flagWe_o      = 1'b0;
    flagRestore_o = 1'b0;
    w_oper        = PC_INC;
    PCEn_o        = 1'b0;
    int_o         = 1'b0;
    push_o        = 1'b0;
    pop_o         = 1'b0;
    int_ack_o     = 1'b0;
    stby_o        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        inst_stb_o = 1'b1;
        irEn_o     = inst_ack_i;
      end
      ST_EXECUTE: begin
        PCEn_o = 1'b1;
        case (class_i)
          CLS_ALU, CLS_SHIFT: begin
            regWe_o  = 1'b1;
            flagWe_o = 1'b1;
          end
          CLS_BZ:  w_oper = PC_BZ;
          CLS_BNZ: w_oper = PC_BNZ;
          CLS_BC:  w_oper = PC_BC;
          CLS_BNC: w_oper = PC_BNC;
          CLS_JMP: w_oper = PC_JMP;
          CLS_JSB: begin
            w_oper = PC_JMP;
            push_o = 1'b1;
          end
          CLS_RET: begin
            w_oper = PC_RET;
            pop_o  = 1'b1;
          end
          CLS_RETI: begin
            w_oper        = PC_RETI;
            flagRestore_o = 1'b1;
          end
          CLS_LDM, CLS_STM, CLS_INP, CLS_OUT: PCEn_o = 1'b0;
          default: ;
        endcase
      end
      ST_MEM: begin
        data_stb_o = 1'b1;
        data_we_o  = w_store;
        port_sel_o = w_port;
        PCEn_o     = w_store && data_ack_i;
      end
      ST_WBACK: begin
        regWe_o = 1'b1;
        PCEn_o  = 1'b1;
      end
      ST_INTR: begin
        int_o     = 1'b1;
        PCEn_o    = 1'b1;
        w_oper    = PC_INT;
        int_ack_o = 1'b1;
      end
      ST_SLEEP: stby_o = (class_i == CLS_STBY);
      default: ;
    endcase
  end

  assign PCoper_o = w_oper;
  assign ie_o     = r_ie;
  assign state_o  = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-instruction cycle schedules are planned from the
// instruction-level rules and compared against the DUT outputs every cycle.
module tb_pc_sequencer;
  import pc_ctrl_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst, clkEn_i, inst_ack_i, data_ack_i, int_req_i;
  instr_class_t class_i;
  logic         inst_stb_o, irEn_o, data_stb_o, data_we_o, port_sel_o;
  logic         regWe_o, flagWe_o, flagRestore_o, PCEn_o, int_o;
  logic         push_o, pop_o, int_ack_o, ie_o, stby_o;
  logic [3:0]   PCoper_o;
  seq_state_t   state_o;

  pc_sequencer #(.INT_EN_RST(1'b0)) dut (
    .clk_i(clk_i), .rst(rst), .clkEn_i(clkEn_i), .class_i(class_i),
    .inst_ack_i(inst_ack_i), .data_ack_i(data_ack_i), .int_req_i(int_req_i),
    .inst_stb_o(inst_stb_o), .irEn_o(irEn_o), .data_stb_o(data_stb_o),
    .data_we_o(data_we_o), .port_sel_o(port_sel_o), .regWe_o(regWe_o),
    .flagWe_o(flagWe_o), .flagRestore_o(flagRestore_o), .PCoper_o(PCoper_o),
    .PCEn_o(PCEn_o), .int_o(int_o), .push_o(push_o), .pop_o(pop_o),
    .int_ack_o(int_ack_o), .ie_o(ie_o), .stby_o(stby_o), .state_o(state_o)
  );

  // ---------------- model / scoreboard ----------------
  typedef struct packed {
    seq_state_t st;
    logic inst_stb, ir_en, data_stb, data_we, port_sel, reg_we, flag_we, flag_restore;
    logic [3:0] oper;
    logic pc_en, int_o, push, pop, int_ack, ie, stby;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  logic [OBS_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit m_ie;

  function automatic obs_t idle(seq_state_t s);
    obs_t o;
    o    = '0;
    o.st = s;
    o.ie = m_ie;
    return o;
  endfunction

  // Execute-cycle behaviour of each class, straight from the instruction table.
  function automatic obs_t exec_obs(instr_class_t c);
    obs_t o;
    o = idle(ST_EXECUTE);
    o.pc_en = 1'b1;
    case (c)
      CLS_ALU, CLS_SHIFT: begin o.reg_we = 1'b1; o.flag_we = 1'b1; end
      CLS_BZ:   o.oper = 4'd2;
      CLS_BNZ:  o.oper = 4'd3;
      CLS_BC:   o.oper = 4'd4;
      CLS_BNC:  o.oper = 4'd5;
      CLS_JMP:  o.oper = 4'd1;
      CLS_JSB:  begin o.oper = 4'd1; o.push = 1'b1; end
      CLS_RET:  begin o.oper = 4'd6; o.pop = 1'b1; end
      CLS_RETI: begin o.oper = 4'd7; o.flag_restore = 1'b1; end
      CLS_LDM, CLS_STM, CLS_INP, CLS_OUT: o.pc_en = 1'b0;
      default: ;
    endcase
    return o;
  endfunction

  function automatic bit ie_after(instr_class_t c, bit ie);
    if (c == CLS_ENAI || c == CLS_RETI) return 1'b1;
    if (c == CLS_DISI) return 1'b0;
    return ie;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge and queue what the DUT must show.
  task automatic cyc(input logic r, input logic en, input logic ia, input logic da,
                     input logic irq, input instr_class_t c, input obs_t o);
    @(negedge clk_i);
    rst = r; clkEn_i = en; inst_ack_i = ia; data_ack_i = da; int_req_i = irq; class_i = c;
    exp_q.push_back(o);
  endtask

  always @(negedge clk_i) begin : compare
    obs_t e, a;
    seq_state_t es;
    #1;
    if (exp_q.size() > 0) begin
      e = obs_t'(exp_q.pop_front());
      a = '0;
      a.st = state_o; a.inst_stb = inst_stb_o; a.ir_en = irEn_o; a.data_stb = data_stb_o;
      a.data_we = data_we_o; a.port_sel = port_sel_o; a.reg_we = regWe_o; a.flag_we = flagWe_o;
      a.flag_restore = flagRestore_o; a.oper = PCoper_o; a.pc_en = PCEn_o; a.int_o = int_o;
      a.push = push_o; a.pop = pop_o; a.int_ack = int_ack_o; a.ie = ie_o; a.stby = stby_o;
      es = e.st;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_%s t=%0t actual=%h expected=%h", es.name(), $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int hold);
    m_ie = 1'b0;
    for (int i = 0; i < hold; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CLS_ALU, idle(ST_RESET));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CLS_ALU, idle(ST_RESET));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CLS_ALU, idle(ST_RESET));
  endtask

  task automatic enter_intr(input instr_class_t c, input bit noise, inout int lat);
    obs_t o;
    o = idle(ST_INTR);
    o.int_o = 1'b1; o.pc_en = 1'b1; o.oper = 4'd8; o.int_ack = 1'b1;
    cyc(1'b1, 1'b1, noise, noise, 1'b1, c, o);
    lat++;
    m_ie = 1'b0;
  endtask

  task automatic fetch_decode(input instr_class_t c, input int iw, input bit irq,
                              input bit noise, input int stall, inout int lat);
    obs_t o;
    for (int w = 0; w <= iw; w++) begin
      o = idle(ST_FETCH);
      o.inst_stb = 1'b1;
      o.ir_en = (w == iw);
      if (w == iw)
        for (int s = 0; s < stall; s++) cyc(1'b1, 1'b0, 1'b1, noise, irq, c, o);
      cyc(1'b1, 1'b1, (w == iw), noise, irq, c, o);
      lat++;
    end
    cyc(1'b1, 1'b1, noise, noise, irq, c, idle(ST_DECODE));
    lat++;
  endtask

  task automatic run_instr(input instr_class_t c, input int iw, input int dw, input bit irq,
                           input bit noise, input int stall, output int lat);
    obs_t o;
    bit ld, st;
    lat = 0;
    ld = (c == CLS_LDM) || (c == CLS_INP);
    st = (c == CLS_STM) || (c == CLS_OUT);
    fetch_decode(c, iw, irq, noise, stall, lat);
    cyc(1'b1, 1'b1, noise, noise, irq, c, exec_obs(c));
    lat++;
    m_ie = ie_after(c, m_ie);
    if (ld || st)
      for (int w = 0; w <= dw; w++) begin
        o = idle(ST_MEM);
        o.data_stb = 1'b1;
        o.data_we  = st;
        o.port_sel = (c == CLS_INP) || (c == CLS_OUT);
        o.pc_en    = st && (w == dw);
        cyc(1'b1, 1'b1, noise, (w == dw), irq, c, o);
        lat++;
      end
    if (ld) begin
      o = idle(ST_WBACK);
      o.reg_we = 1'b1; o.pc_en = 1'b1;
      cyc(1'b1, 1'b1, noise, noise, irq, c, o);
      lat++;
    end
    if (irq && m_ie) enter_intr(c, noise, lat);
  endtask

  // WAIT/STBY: sleeps n cycles; the last sleeping cycle carries 'wake' on int_req.
  task automatic run_sleep(input instr_class_t c, input int n, input bit irq_sleep, input bit wake);
    obs_t o;
    int lat;
    bit r;
    lat = 0;
    fetch_decode(c, 0, 1'b0, 1'b0, 0, lat);
    o = idle(ST_EXECUTE);
    o.pc_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c, o);
    for (int i = 0; i < n; i++) begin
      r = (i == n - 1) ? wake : irq_sleep;
      o = idle(ST_SLEEP);
      o.stby = (c == CLS_STBY);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, r, c, o);
      if (r && m_ie) begin
        enter_intr(c, 1'b0, lat);
        return;
      end
    end
  endtask

  task automatic run_mem_reset();
    obs_t o;
    int lat;
    lat = 0;
    fetch_decode(CLS_LDM, 0, 1'b0, 1'b0, 0, lat);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CLS_LDM, exec_obs(CLS_LDM));
    o = idle(ST_MEM);
    o.data_stb = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CLS_LDM, o);
    @(negedge clk_i);
    data_ack_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_mem_data_stb", data_stb_o, 1'b0);
    check("rst_mid_mem_state", state_o, ST_RESET);
    check("rst_mid_mem_regwe", regWe_o, 1'b0);
    do_reset(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    instr_class_t c;
    rst = 1'b0; clkEn_i = 1'b1; inst_ack_i = 1'b0; data_ack_i = 1'b0;
    int_req_i = 1'b0; class_i = CLS_ALU; m_ie = 1'b0;

    do_reset(2);

    run_instr(CLS_ALU, 0, 0, 1'b0, 1'b0, 0, lat);  check("lat_alu", lat, 3);
    run_instr(CLS_LDM, 0, 2, 1'b0, 1'b0, 0, lat);  check("lat_ldm_ack_wait2", lat, 7);
    run_instr(CLS_STM, 0, 0, 1'b0, 1'b0, 0, lat);  check("lat_stm", lat, 4);
    run_instr(CLS_INP, 0, 0, 1'b0, 1'b0, 0, lat);  check("lat_inp", lat, 5);
    run_instr(CLS_OUT, 1, 1, 1'b0, 1'b1, 0, lat);  check("lat_out_waits", lat, 6);
    run_instr(CLS_SHIFT, 2, 0, 1'b0, 1'b1, 2, lat);
    for (int k = int'(CLS_BZ); k <= int'(CLS_JMP); k++)
      run_instr(instr_class_t'(k), 0, 0, 1'b1, 1'b0, 0, lat);

    run_instr(CLS_ENAI, 0, 0, 1'b1, 1'b0, 0, lat); check("lat_enai_intr", lat, 4);
    run_instr(CLS_ENAI, 0, 0, 1'b0, 1'b0, 0, lat);
    run_instr(CLS_DISI, 0, 0, 1'b1, 1'b0, 0, lat); check("lat_disi_blocks", lat, 3);
    run_instr(CLS_ALU, 0, 0, 1'b1, 1'b0, 0, lat);

    run_instr(CLS_JSB, 0, 0, 1'b0, 1'b0, 0, lat);
    run_instr(CLS_RET, 0, 0, 1'b0, 1'b0, 0, lat);

    run_instr(CLS_ENAI, 0, 0, 1'b0, 1'b0, 0, lat);
    run_sleep(CLS_WAIT, 3, 1'b0, 1'b1);
    run_instr(CLS_RETI, 0, 0, 1'b0, 1'b0, 0, lat);
    run_instr(CLS_ALU, 0, 0, 1'b1, 1'b0, 0, lat);  check("lat_alu_intr", lat, 4);
    run_instr(CLS_RETI, 0, 0, 1'b1, 1'b0, 0, lat); check("lat_reti_pending", lat, 4);
    run_instr(CLS_ENAI, 0, 0, 1'b0, 1'b0, 0, lat);
    run_instr(CLS_LDM, 1, 1, 1'b1, 1'b0, 0, lat);  check("lat_ldm_waits_intr", lat, 8);

    run_sleep(CLS_STBY, 4, 1'b1, 1'b1);
    do_reset(1);

    run_mem_reset();
    run_instr(CLS_ALU, 0, 0, 1'b0, 1'b0, 0, lat);

    for (int n = 0; n < 30; n++) begin
      c = instr_class_t'(5'($urandom_range(0, 15)));
      run_instr(c, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 1), lat);
    end

    @(negedge clk_i);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
